i2osp_serializer: RTL and testbench

I2OSP_SERIALIZER -- requirements
Module: i2osp_serializer

---
 rtl/i2osp_serializer.sv | 117 +++++++++++
 tb/tb_i2osp_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2osp_serializer.sv
// I2OSP octet-string serializer: converts a captured integer into xLen big-endian
// octets streamed over a valid/ready handshake, rejecting bad lengths and oversize values.
module i2osp_serializer #(
  parameter int unsigned DATA_BIT_WIDTH = 2048
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_BIT_WIDTH-1:0] x_in,
  input  logic [8:0]                x_len,
  output logic [7:0]                out_byte,
  output logic [7:0]                out_index,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned MAX_BYTES = DATA_BIT_WIDTH / 8;
  localparam int unsigned LEN_W     = 9;
  localparam int unsigned IDX_W     = 8;

  typedef enum logic [1:0] {IDLE, CHECK, SEND, DONE} state_t;

  state_t                    r_state;
  logic [DATA_BIT_WIDTH-1:0] r_x;
  logic [LEN_W-1:0]          r_len;
  logic [IDX_W-1:0]          r_idx;

  logic                      w_bad_len;
  logic                      w_too_large;
  logic                      w_xfer;
  logic [IDX_W-1:0]          w_next_idx;
  logic [LEN_W-1:0]          w_pos;
  logic [7:0]                w_next_byte;
  logic                      w_next_last;

  // Length and magnitude checks on the captured operands; a full-width length can never overflow.
  assign w_bad_len   = (r_len == '0) || (r_len > LEN_W'(MAX_BYTES));
  assign w_too_large = (r_len < LEN_W'(MAX_BYTES)) && ((r_x >> {r_len, 3'b000}) != '0);
  assign w_xfer      = out_valid & out_ready;

  // Octet to present next: index 0 when leaving CHECK, otherwise the one after the current.
  assign w_next_idx  = (r_state == CHECK) ? '0 : r_idx + IDX_W'(1);
  assign w_pos       = r_len - LEN_W'(1) - {1'b0, w_next_idx};
  assign w_next_byte = 8'(r_x >> {w_pos, 3'b000});
  assign w_next_last = ({1'b0, w_next_idx} == (r_len - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      out_byte  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x     <= x_in;
            r_len   <= x_len;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_bad_len || w_too_large) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_idx     <= w_next_idx;
            out_valid <= 1'b1;
            out_byte  <= w_next_byte;
            out_index <= w_next_idx;
            out_last  <= w_next_last;
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (w_xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_byte  <= '0;
              out_index <= '0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_idx     <= w_next_idx;
              out_byte  <= w_next_byte;
              out_index <= w_next_idx;
              out_last  <= w_next_last;
            end
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2osp_serializer.sv
// Scoreboard bench for i2osp_serializer: a reference model queues expected octets,
// err and done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_i2osp_serializer;

  typedef struct {
    int         kind;   // 0 = octet, 1 = err, 2 = done
    logic [7:0] b;
    logic [7:0] idx;
    logic       last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2047:0] x_in;
  logic [8:0]    x_len;
  logic [7:0]    out_byte;
  logic [7:0]    out_index;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   xfer_cnt = 0;
  int   rdy_mode = 0;
  int   pidx = 0;
  bit   prev_stall = 0;
  logic [16:0] prev_vals;
  bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  i2osp_serializer #(.DATA_BIT_WIDTH(2048)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .x_len(x_len),
    .out_byte(out_byte), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer: always ready, random, or the fixed 1,0,0,1,0,1 pattern over valid cycles.
  always @(posedge clk) begin
    #1;
    if (!busy) pidx = 0;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = pat[pidx];
        if (out_valid) pidx = (pidx + 1) % 6;
      end
    endcase
  end

  // Monitor: compare every transfer and pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      check("err_done_exclusive", 64'(err && done), 64'd0);
      if (prev_stall)
        check("stall_hold", 64'({out_valid, out_byte, out_index}), 64'({1'b1, prev_vals[16:1]}) );
      if (prev_stall)
        check("stall_hold_last", 64'(out_last), 64'(prev_vals[0]));
      if (!out_valid)
        check("idle_outputs_zero", 64'({out_byte, out_index, out_last}), 64'd0);
      if (out_valid && out_ready) begin
        xfer_cnt++;
        check("sb_pending_octet", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("kind_octet", 64'd0, 64'(e.kind));
          check("out_byte", 64'(out_byte), 64'(e.b));
          check("out_index", 64'(out_index), 64'(e.idx));
          check("out_last", 64'(out_last), 64'(e.last));
        end
      end
      if (err || done) begin
        check("sb_pending_pulse", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check(err ? "kind_err" : "kind_done", 64'(err ? 1 : 2), 64'(e.kind));
        end
      end
    end
    prev_stall = rst_n && out_valid && !out_ready;
    prev_vals  = {out_byte, out_index, out_last};
  end

  // Reference: the octet string is x written in base 256, MSB first, padded to len digits.
  function automatic bit model_push(input logic [2047:0] x, input int len);
    logic [2047:0] t;
    logic [7:0]    bs[256];
    exp_t          ex;
    bit            ok;
    ok = (len >= 1) && (len <= 256);
    if (ok && len < 256) ok = ((x >> (8 * len)) == '0);
    if (!ok) begin
      ex = '{1, 8'd0, 8'd0, 1'b0};
      q.push_back(ex);
      return 1'b0;
    end
    t = x;
    for (int i = len - 1; i >= 0; i--) begin
      bs[i] = 8'(t % 256);
      t     = t / 256;
    end
    for (int i = 0; i < len; i++) begin
      ex = '{0, bs[i], 8'(i), (i == len - 1)};
      q.push_back(ex);
    end
    ex = '{2, 8'd0, 8'd0, 1'b0};
    q.push_back(ex);
    return 1'b1;
  endfunction

  function automatic logic [2047:0] rand_x(input int len, input bit big);
    logic [2047:0] x;
    logic [2047:0] m;
    for (int i = 0; i < 64; i++) x[i*32 +: 32] = $urandom;
    if (!big && len >= 1 && len < 256) begin
      m = '1;
      m = m >> (2048 - 8 * len);
      x = x & m;
    end
    return x;
  endfunction

  task automatic send(input logic [2047:0] x, input int len, input bit poke,
                      output int lat_v, output int lat_d, output int lat_e);
    bit valid;
    bit fin;
    valid = model_push(x, len);
    lat_v = -1; lat_d = -1; lat_e = -1; fin = 0;
    start = 1'b1; x_in = x; x_len = 9'(len);
    tick();
    start = 1'b0;
    x_in  = rand_x(256, 1'b1);
    for (int n = 1; n <= 3000; n++) begin
      tick();
      start = poke && valid && (len >= 3) && (n == 3);
      if (start) begin x_in = rand_x(8, 1'b0); x_len = 9'($urandom_range(1, 8)); end
      if (out_valid && lat_v < 0) lat_v = n + 1;
      if (done && lat_d < 0) lat_d = n + 1;
      if (err && lat_e < 0) lat_e = n + 1;
      if (!busy) begin fin = 1; break; end
    end
    start = 1'b0;
    check("conversion_timeout", 64'(fin), 64'd1);
    tick();
  endtask

  int lv, ld, le, len;
  bit fin;
  logic [2047:0] xr;

  initial begin
    rst_n = 1'b0; start = 1'b0; x_in = '0; x_len = '0;
    repeat (3) tick();
    check("reset_outputs", 64'({out_byte, out_index, out_valid, out_last, busy, done, err}), 64'd0);
    rst_n = 1'b1;
    tick();

    rdy_mode = 0;
    send(2048'h0102_0304, 4, 1'b0, lv, ld, le);
    check("basic_first_valid_latency", 64'(lv), 64'd2);
    check("basic_done_latency", 64'(ld), 64'd6);

    send(2048'hABCD, 5, 1'b0, lv, ld, le);
    check("pad_no_err", 64'(le == -1), 64'd1);

    send(2048'h0100, 1, 1'b0, lv, ld, le);
    check("too_large_err_latency", 64'(le), 64'd2);
    check("too_large_no_valid", 64'(lv == -1), 64'd1);
    check("too_large_busy_low", 64'(busy), 64'd0);

    send(2048'hFF, 1, 1'b0, lv, ld, le);
    check("ff_done_latency", 64'(ld), 64'd3);

    rdy_mode = 2;
    send(2048'h112233, 3, 1'b0, lv, ld, le);
    rdy_mode = 0;

    send(2048'h5, 0, 1'b0, lv, ld, le);
    check("len0_err", 64'(le), 64'd2);
    send(2048'h5, 257, 1'b0, lv, ld, le);
    check("len257_err", 64'(le), 64'd2);
    send('1, 256, 1'b0, lv, ld, le);
    check("len256_no_err", 64'(le == -1), 64'd1);

    // Reset after the second octet of an 8-octet string, with start held during reset.
    xr = rand_x(8, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      if (i >= 6) q.push_back('{0, 8'(xr >> (8 * i)), 8'(7 - i), 1'b0});
    end
    xfer_cnt = 0; fin = 0;
    start = 1'b1; x_in = xr; x_len = 9'd8;
    tick();
    start = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (xfer_cnt == 2) begin fin = 1; break; end
    end
    check("reset_wait_timeout", 64'(fin), 64'd1);
    rst_n = 1'b0; start = 1'b1; x_in = rand_x(4, 1'b0); x_len = 9'd4;
    tick();
    check("midop_reset_outputs", 64'({out_byte, out_index, out_valid, out_last, busy, done, err}), 64'd0);
    rst_n = 1'b1; start = 1'b0;
    tick(); tick();
    check("start_in_reset_ignored", 64'(busy), 64'd0);
    check("reset_sb_drained", 64'(q.size()), 64'd0);
    send(rand_x(8, 1'b0), 8, 1'b1, lv, ld, le);

    // Random sweep: lengths around the interesting edges, random backpressure, stray starts.
    for (int it = 0; it < 40; it++) begin
      rdy_mode = (it % 3 == 0) ? 0 : 1;
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(1, 24));
      send(rand_x(len, $urandom_range(0, 4) == 0), len, 1'($urandom_range(0, 1)), lv, ld, le);
    end

    check("sb_empty_at_end", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
